// File: rtl/quadra_result_buf.sv
// Result buffer for the quadratic evaluator: a DEPTH-entry FIFO of {x operand, y result}
// pairs with an accepted-sample counter and a sticky overflow flag.
module quadra_result_buf #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [23:0]              in_x,
    input  logic [24:0]              in_y,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [23:0]              out_x,
    output logic [24:0]              out_y,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic                     ovf_err,
    input  logic                     clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 49;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_p0;
    logic [PTR_W-1:0] rd_ptr_p0;
    logic [LVL_W-1:0] level_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             ovf_p0;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Occupancy update; push and pop are already qualified, so the result stays in 0..DEPTH.
    function automatic logic [LVL_W-1:0] next_level(input logic [LVL_W-1:0] cur,
                                                   input logic push_i,
                                                   input logic pop_i);
        logic [LVL_W-1:0] nxt;
        nxt = cur;
        if (push_i && !pop_i) begin
            nxt = cur + LVL_W'(1);
        end else if (pop_i && !push_i) begin
            nxt = cur - LVL_W'(1);
        end
        return nxt;
    endfunction

    assign in_ready  = (level_p0 != LVL_W'(DEPTH));
    assign out_valid = (level_p0 != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is write-only from the push side; reset just makes it unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_p0] <= {in_x, in_y};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            level_p0  <= '0;
            cnt_p0    <= '0;
        end else begin
            if (push) begin
                wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(1);
                cnt_p0    <= cnt_p0 + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
            end
            level_p0 <= next_level(level_p0, push, pop);
        end
    end

    // A rejected push outranks a same-cycle clear so no overflow is ever lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_p0 <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf_p0 <= 1'b1;
        end else if (clr_err) begin
            ovf_p0 <= 1'b0;
        end
    end

    assign head       = out_valid ? mem[rd_ptr_p0] : '0;
    assign out_x      = head[48:25];
    assign out_y      = head[24:0];
    assign level      = level_p0;
    assign sample_cnt = cnt_p0;
    assign ovf_err    = ovf_p0;

endmodule

// File: tb/tb_quadra_result_buf.sv
// Randomised scoreboard bench for quadra_result_buf (DEPTH=4, CNT_W=4).
module tb_quadra_result_buf;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] in_x;
    logic [24:0] in_y;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_x;
    logic [24:0] out_y;
    logic        out_ready;
    logic [2:0]  level;
    logic [3:0]  sample_cnt;
    logic        ovf_err;
    logic        clr_err;

    quadra_result_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_ready(in_ready), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .out_ready(out_ready), .level(level), .sample_cnt(sample_cnt),
        .ovf_err(ovf_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          armed  = 0;
    int          mlvl   = 0;
    int          mcnt   = 0;
    bit          movf   = 0;
    logic [48:0] sb [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO is just a bounded queue; accepted pushes feed the scoreboard.
    always @(posedge clk) begin
        bit push_ok, pop_ok;
        if (!rst_n) begin
            armed = 1;
            mlvl  = 0;
            mcnt  = 0;
            movf  = 0;
            sb.delete();
        end else begin
            push_ok = in_valid && (mlvl < DEPTH);
            pop_ok  = out_ready && (mlvl > 0);
            if (in_valid && mlvl == DEPTH) movf = 1;
            else if (clr_err) movf = 0;
            if (push_ok) begin
                sb.push_back({in_x, in_y});
                mcnt = (mcnt + 1) % (1 << CNT_W);
            end
            mlvl = mlvl + int'(push_ok) - int'(pop_ok);
        end
    end

    // Monitor: compares status and head entry, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (armed) begin
            chk("level", 64'(level), 64'(mlvl));
            chk("in_ready", 64'(in_ready), 64'(mlvl != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(mlvl != 0));
            chk("sample_cnt", 64'(sample_cnt), 64'(mcnt));
            chk("ovf_err", 64'(ovf_err), 64'(movf));
            if (sb.size() != 0) begin
                chk("out_x", 64'(out_x), 64'(sb[0][48:25]));
                chk("out_y", 64'(out_y), 64'(sb[0][24:0]));
                if (rst_n && out_ready) void'(sb.pop_front());
            end else begin
                chk("out_x_idle", 64'(out_x), 64'd0);
                chk("out_y_idle", 64'(out_y), 64'd0);
            end
            if (out_valid && out_y == 25'h1FFFFFF) chk("rejected_seen", 64'(out_y), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr_err = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b0;
        clr_err = 1'b0;
        do_reset(2);
        @(negedge clk);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cnt", 64'(sample_cnt), 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        step();

        // Fill with y = 1..4, consumer stalled
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_x = 24'($urandom);
            in_y = 25'(i);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_level", 64'(level), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step();

        // Overflow attempt, then clear, then clear colliding with another overflow
        in_valid = 1'b1;
        in_y = 25'h1FFFFFF;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set", 64'(ovf_err), 64'd1);
        chk("ovf_level", 64'(level), 64'd4);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        @(negedge clk);
        chk("ovf_clr", 64'(ovf_err), 64'd0);
        step();
        in_valid = 1'b1;
        clr_err = 1'b1;
        step();
        in_valid = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        chk("ovf_prio", 64'(ovf_err), 64'd1);
        step();

        // Drain: y should come out 1,2,3,4 (checked by monitor)
        out_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("drained", 64'(out_valid), 64'd0);
        step();

        // Streaming from empty after a fresh reset
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            out_ready = 1'b1;
            in_x = 24'($urandom);
            in_y = 25'($urandom);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_cnt", 64'(sample_cnt), 64'd10);
        chk("stream_level", 64'(level), 64'd1);
        step();
        step();

        // Random traffic: producer-heavy then consumer-heavy to exercise full/empty and wraps
        for (int i = 0; i < 400; i++) begin
            in_valid  = (i < 200) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
            out_ready = (i < 200) ? ($urandom_range(2, 0) == 0) : ($urandom_range(3, 0) != 0);
            clr_err   = ($urandom_range(15, 0) == 0);
            in_x = 24'($urandom);
            in_y = 25'($urandom);
            step();
        end
        in_valid = 1'b0;
        clr_err = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();

        // Mid-operation reset with level 3 and a push attempt
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x = 24'($urandom);
            in_y = 25'($urandom);
            step();
        end
        rst_n = 1'b0;
        in_valid = 1'b1;
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("midrst_empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/quadra_result_buf.md
QUADRA_RESULT_BUF -- requirements
Module: quadra_result_buf

Interface
REQ-001 Parameter: DEPTH, 4, number of FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter: CNT_W, 16, width of the accepted-sample counter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: in_valid  input  1  a quadra result is presented this cycle.
REQ-006 Port: in_x  input  24  x_t operand that produced the result (x1 = [23:17], x2 = [16:0]).
REQ-007 Port: in_y  input  25  y_t result from the quadratic evaluator.
REQ-008 Port: in_ready  output  1  buffer can accept a push this cycle.
REQ-009 Port: out_valid  output  1  head entry is available.
REQ-010 Port: out_x  output  24  operand tag of the head entry.
REQ-011 Port: out_y  output  25  result of the head entry.
REQ-012 Port: out_ready  input  1  consumer takes the head entry this cycle.
REQ-013 Port: level  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-014 Port: sample_cnt  output  CNT_W  count of accepted pushes; wraps modulo 2^CNT_W.
REQ-015 Port: ovf_err  output  1  sticky flag: a push was attempted while full.
REQ-016 Port: clr_err  input  1  synchronous clear of ovf_err.

Function
REQ-017 The block SHALL be a DEPTH-entry first-in first-out buffer storing {in_x, in_y} pairs, i.e. 49 bits per entry.
REQ-018 A push SHALL occur when in_valid and in_ready are both 1 at a rising clk edge.
REQ-019 A pop SHALL occur when out_valid and out_ready are both 1 at a rising clk edge.
REQ-020 in_ready SHALL equal (level != DEPTH); a pop in the same cycle SHALL NOT raise in_ready combinationally.
REQ-021 out_valid SHALL equal (level != 0).
REQ-022 Latency: a pushed entry SHALL appear on out_x/out_y with out_valid=1 on the cycle after the push when the buffer was empty (one-cycle latency, no fall-through).
REQ-023 out_x/out_y SHALL be driven from the head entry while out_valid=1, and SHALL be all-zero while out_valid=0.
REQ-024 Ordering: entries SHALL be popped in exactly the order pushed, with no loss or duplication.
REQ-025 Write and read pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-026 A simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-027 A push alone SHALL increment level by 1; a pop alone SHALL decrement it by 1; level SHALL never exceed DEPTH or go below 0.
REQ-028 When empty, a push with out_ready=1 in the same cycle SHALL store the entry; the entry SHALL be popped no earlier than the following cycle.
REQ-029 sample_cnt SHALL increment by 1 on every push, wrapping from 2^CNT_W-1 to 0.
REQ-030 ovf_err SHALL be set on the cycle after in_valid=1 while in_ready=0; the rejected data SHALL be discarded.
REQ-031 clr_err=1 SHALL clear ovf_err on the next edge; if an overflow attempt occurs in the same cycle, set SHALL take priority.
REQ-032 in_x and in_y SHALL be stored unmodified; no arithmetic or re-quantisation SHALL be applied.

Reset
REQ-033 With rst_n=0 at a rising edge, the block SHALL set the pointers to 0, level to 0, sample_cnt to 0 and ovf_err to 0.
REQ-034 During and after reset, the block SHALL drive out_valid=0, out_x=0, out_y=0 and in_ready=1.
REQ-035 Storage contents SHALL NOT be reset and SHALL NOT be observable until written.
REQ-036 Reset asserted mid-operation SHALL discard all stored entries, overriding any push or pop in that cycle.

Verification
REQ-037 Reset then idle: rst_n low for 2 cycles -> out_valid=0, in_ready=1, level=0, sample_cnt=0, ovf_err=0.
REQ-038 Fill and drain: 4 pushes with out_ready=0, y=0x0000001..0x0000004 -> level=4 and in_ready=0; then out_ready=1 -> y pops as 1,2,3,4 on consecutive cycles, then out_valid=0.
REQ-039 Overflow: when full, in_valid=1 with y=0x1FFFFFF -> ovf_err=1 next cycle, level stays 4, and 0x1FFFFFF is never output; clr_err=1 -> ovf_err=0.
REQ-040 Streaming: in_valid=1 and out_ready=1 continuously for 10 cycles from empty -> level stays at 1 after the first cycle, outputs match inputs delayed by one cycle, and sample_cnt=10.
REQ-041 Wrap and counter: with CNT_W=4, perform 17 pushes interleaved with pops -> pointers wrap without corruption and sample_cnt=1.
REQ-042 Mid-operation reset: with level=3, rst_n=0 for one cycle with in_valid=1 -> level=0, out_valid=0, and no entry is stored.
